key_note_player: RTL and testbench

- Downstream consumer of the APB keypad block: takes the key-event interrupt pulse and the debounced 16-bit held-key bitmap.
- Maps the selected key to one of 16 chromatic notes (C4..D#5), with an optional octave shift.
- Drives the buzzer pin with a 50%-duty square wave while the key is held, then holds the note for a minimum duration.
- Sits between the keypad and the buzzer pad; also exports status for a later APB status register.

---
 rtl/key_note_player_pkg.sv | 26 ++
 rtl/key_note_player_tone_gen.sv | 50 +++++
 rtl/key_note_player.sv | 136 +++++++++++++
 tb/tb_key_note_player.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/key_note_player_pkg.sv
// key_note_pkg: shared constants and types for the key-to-note player.
//   NOTE_FREQ   - chromatic note frequencies C4..D#5 in Hz, indexed by key number
//   state_t     - player FSM encoding (IDLE / PLAY / TAIL)
//   half_period - elaboration-time helper: clock cycles per half wave of a note
package key_note_pkg;

    localparam int NUM_NOTES = 16;

    localparam int NOTE_FREQ [0:NUM_NOTES-1] = '{
        262, 277, 294, 311, 330, 349, 370, 392,
        415, 440, 466, 494, 523, 554, 587, 622
    };

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_TAIL = 2'd2
    } state_t;

    // Truncating division; the caller narrows the result to its counter width.
    function automatic logic [31:0] half_period(input int unsigned clk_freq,
                                                input int unsigned freq);
        return 32'(clk_freq / (2 * freq));
    endfunction

endpackage

// File: rtl/key_note_player_tone_gen.sv
// key_note_player_tone_gen: half-period counter driving a 50%-duty square wave.
//   clk, rst_n  - clock, synchronous active-low reset
//   i_load      - latch i_half, clear the counter, force the output low
//   i_run       - count and toggle; when low (and not loading) the output is held low
//   i_half      - half period in clock cycles (must be >= 1)
//   o_buzzer    - square-wave output
module key_note_player_tone_gen
    import key_note_pkg::*;
#(
    parameter int PERIOD_W = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_load,
    input  logic                i_run,
    input  logic [PERIOD_W-1:0] i_half,
    output logic                o_buzzer
);

    logic [PERIOD_W-1:0] r_half;
    logic [PERIOD_W-1:0] r_cnt;
    logic                r_buzzer;
    logic                w_wrap;

    assign w_wrap   = (r_cnt == r_half - PERIOD_W'(1));
    assign o_buzzer = r_buzzer;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_half   <= '0;
            r_cnt    <= '0;
            r_buzzer <= 1'b0;
        end else if (i_load) begin
            r_half   <= i_half;
            r_cnt    <= '0;
            r_buzzer <= 1'b0;
        end else if (i_run) begin
            if (w_wrap) begin
                r_cnt    <= '0;
                r_buzzer <= ~r_buzzer;
            end else begin
                r_cnt <= r_cnt + PERIOD_W'(1);
            end
        end else begin
            r_cnt    <= '0;
            r_buzzer <= 1'b0;
        end
    end

endmodule

// File: rtl/key_note_player.sv
// key_note_player: plays the lowest pressed keypad key as a square-wave tone.
//   clk, rst_n - clock, synchronous active-low reset
//   enable     - low forces IDLE on the next edge (beats key_evt)
//   key_evt    - one-cycle key-press event from the keypad
//   key[15:0]  - held-key bitmap; lowest set bit selects the note
//   octave     - up-shift 0..3 applied to the note at start
//   buzzer     - 50%-duty square wave to the buzzer pad
//   playing    - high while in PLAY or TAIL
//   note_idx   - index of the current (or last) note
//
// Valid/ready note: there is no handshake; key_evt is a fire-and-forget pulse
// that is acted on in the cycle it is high, and outputs are registered.
module key_note_player
    import key_note_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int MIN_CYCLES = 2_500_000,
    parameter int PERIOD_W   = 20,
    parameter int MIN_W      = 22
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        key_evt,
    input  logic [15:0] key,
    input  logic [1:0]  octave,
    output logic        buzzer,
    output logic        playing,
    output logic [3:0]  note_idx
);

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_note_idx;
    logic [MIN_W-1:0]    r_min_cnt;

    logic [PERIOD_W-1:0] w_hp_table [NUM_NOTES];
    logic [3:0]          w_sel;
    logic [PERIOD_W-1:0] w_shifted;
    logic [PERIOD_W-1:0] w_half;
    logic                w_start;
    logic                w_min_done;
    logic                w_released;
    logic                w_load;
    logic                w_run;
    logic                w_buzzer;

    // Half-period per note at octave 0, fixed at elaboration.
    for (genvar gi = 0; gi < NUM_NOTES; gi++) begin : g_hp_table
        assign w_hp_table[gi] = PERIOD_W'(half_period(CLK_FREQ, NOTE_FREQ[gi]));
    end

    // Lowest set bit wins: scan downwards so the last hit is the lowest index.
    always_comb begin
        w_sel = '0;
        for (int i = NUM_NOTES - 1; i >= 0; i--) begin
            if (key[i]) begin
                w_sel = 4'(i);
            end
        end
    end

    // The octave only affects the half period, which the tone generator
    // latches on load, so it needs no separate register here.
    assign w_shifted  = w_hp_table[w_sel] >> octave;
    assign w_half     = (w_shifted == '0) ? PERIOD_W'(1) : w_shifted;

    assign w_start    = key_evt && (key != 16'h0000);
    assign w_min_done = (r_min_cnt >= MIN_W'(MIN_CYCLES));
    assign w_released = !key[r_note_idx];

    // Priority: disable, then (re)trigger, then release/tail handling.
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        if (!enable) begin
            w_next = S_IDLE;
        end else if (w_start) begin
            w_next = S_PLAY;
            w_load = 1'b1;
        end else begin
            case (r_state)
                S_PLAY: begin
                    if (w_released) begin
                        w_next = w_min_done ? S_IDLE : S_TAIL;
                    end
                end
                S_TAIL: begin
                    if (w_min_done) begin
                        w_next = S_IDLE;
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
        // Keep the tone running only while a note continues through this edge;
        // leaving to IDLE clears the buzzer on the same edge.
        w_run = (r_state != S_IDLE) && (w_next != S_IDLE) && !w_load;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_note_idx <= '0;
            r_min_cnt  <= '0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_note_idx <= w_sel;
                r_min_cnt  <= '0;
            end else if (w_run) begin
                if (!w_min_done) begin
                    r_min_cnt <= r_min_cnt + MIN_W'(1);
                end
            end else begin
                r_min_cnt <= '0;
            end
        end
    end

    key_note_player_tone_gen #(
        .PERIOD_W (PERIOD_W)
    ) u_tone_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_load),
        .i_run    (w_run),
        .i_half   (w_half),
        .o_buzzer (w_buzzer)
    );

    assign buzzer   = w_buzzer;
    assign playing  = (r_state != S_IDLE);
    assign note_idx = r_note_idx;

endmodule

// File: tb/tb_key_note_player.sv
// Bench for key_note_player. Output events (any change of buzzer/playing/note_idx)
// are predicted with their cycle numbers when stimulus is issued and checked
// by per-DUT monitors on the falling clock edge.
module tb_key_note_player;

    localparam int EW = 38;   // {cycle[31:0], buzzer, playing, note_idx[3:0]}

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        key_evt;
    logic [15:0] key;
    logic [1:0]  octave;
    logic        buzzer;
    logic        playing;
    logic [3:0]  note_idx;

    logic        f_key_evt;
    logic [15:0] f_key;
    logic [1:0]  f_octave;
    logic        f_buzzer;
    logic        f_playing;
    logic [3:0]  f_note_idx;

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic        mon_en = 1'b0;
    logic [5:0]  prev_s = '0;
    logic [5:0]  prev_f = '0;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] exp_f_q[$];

    key_note_player #(
        .CLK_FREQ   (1_000_000),
        .MIN_CYCLES (100)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .key_evt  (key_evt),
        .key      (key),
        .octave   (octave),
        .buzzer   (buzzer),
        .playing  (playing),
        .note_idx (note_idx)
    );

    key_note_player #(
        .CLK_FREQ   (1000),
        .MIN_CYCLES (4)
    ) dut_fast (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .key_evt  (f_key_evt),
        .key      (f_key),
        .octave   (f_octave),
        .buzzer   (f_buzzer),
        .playing  (f_playing),
        .note_idx (f_note_idx)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- helpers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int c, input logic b, input logic p, input logic [3:0] i);
        exp_q.push_back({32'(c), b, p, i});
    endtask

    task automatic push_f(input int c, input logic b, input logic p, input logic [3:0] i);
        exp_f_q.push_back({32'(c), b, p, i});
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic check_ev(input string name, input logic [EW-1:0] exp, input logic [EW-1:0] got);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got cyc=%0d buz/play/idx=%b/%b/%0d, expected cyc=%0d buz/play/idx=%b/%b/%0d",
                     name, got[37:6], got[5], got[4], got[3:0], exp[37:6], exp[5], exp[4], exp[3:0]);
        end
    endtask

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        logic [5:0] cur;
        if (mon_en) begin
            cur = {buzzer, playing, note_idx};
            if (cur !== prev_s) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL dut_unexpected: cyc=%0d buz/play/idx=%b/%b/%0d, expected no change",
                             cyc, cur[5], cur[4], cur[3:0]);
                end else begin
                    check_ev("dut_event", exp_q.pop_front(), {32'(cyc), cur});
                end
                prev_s = cur;
            end
        end
    end

    always @(negedge clk) begin
        logic [5:0] cur;
        if (mon_en) begin
            cur = {f_buzzer, f_playing, f_note_idx};
            if (cur !== prev_f) begin
                if (exp_f_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL fast_unexpected: cyc=%0d buz/play/idx=%b/%b/%0d, expected no change",
                             cyc, cur[5], cur[4], cur[3:0]);
                end else begin
                    check_ev("fast_event", exp_f_q.pop_front(), {32'(cyc), cur});
                end
                prev_f = cur;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int t;
        int t2;
        rst_n     = 1'b0;
        enable    = 1'b1;
        key_evt   = 1'b0;
        key       = '0;
        octave    = '0;
        f_key_evt = 1'b0;
        f_key     = '0;
        f_octave  = '0;
        step(3);

        check("reset_buzzer",   32'(buzzer),   0);
        check("reset_playing",  32'(playing),  0);
        check("reset_note_idx", 32'(note_idx), 0);
        check("reset_fast_out", 32'({f_buzzer, f_playing, f_note_idx}), 0);
        prev_s = '0;
        prev_f = '0;
        mon_en = 1'b1;
        rst_n  = 1'b1;
        step(2);

        // 1: note 9 (A4), H = 1e6/880 = 1136, held 5000 cycles
        key = 16'h0200; octave = 2'd0; key_evt = 1'b1; t = cyc;
        push(t + 1, 1'b0, 1'b1, 4'd9);
        for (int k = 1; k <= 4; k++) push(t + 1 + 1136 * k, 1'(k % 2), 1'b1, 4'd9);
        push(t + 5001, 1'b0, 1'b0, 4'd9);
        step(1); key_evt = 1'b0;
        step(4999); key = '0;
        step(20);

        // 2: same key, octave 2 -> H = 284, held 1200 cycles
        key = 16'h0200; octave = 2'd2; key_evt = 1'b1; t = cyc;
        push(t + 1, 1'b0, 1'b1, 4'd9);
        for (int k = 1; k <= 4; k++) push(t + 1 + 284 * k, 1'(k % 2), 1'b1, 4'd9);
        push(t + 1201, 1'b0, 1'b0, 4'd9);
        step(1); key_evt = 1'b0;
        step(1199); key = '0;
        step(20);

        // 3: note 0 released after 10 cycles -> tail until min count 100
        key = 16'h0001; octave = 2'd0; key_evt = 1'b1; t = cyc;
        push(t + 1, 1'b0, 1'b1, 4'd0);
        push(t + 102, 1'b0, 1'b0, 4'd0);
        step(1); key_evt = 1'b0;
        step(9); key = '0;
        step(120);

        // 4: note 4 (H=1515), retrigger to note 0 (H=1908) while buzzer is high
        key = 16'h0110; key_evt = 1'b1; t = cyc;
        push(t + 1, 1'b0, 1'b1, 4'd4);
        push(t + 1516, 1'b1, 1'b1, 4'd4);
        step(1); key_evt = 1'b0;
        step(1599);
        key = 16'h0011; key_evt = 1'b1; t2 = cyc;
        push(t2 + 1, 1'b0, 1'b1, 4'd0);
        for (int k = 1; k <= 2; k++) push(t2 + 1 + 1908 * k, 1'(k % 2), 1'b1, 4'd0);
        push(t2 + 4001, 1'b0, 1'b0, 4'd0);
        step(1); key_evt = 1'b0;
        step(3999); key = '0;
        step(20);

        // 5a: enable=0 together with key_evt while buzzer is high
        key = 16'h0200; key_evt = 1'b1; t = cyc;
        push(t + 1, 1'b0, 1'b1, 4'd9);
        push(t + 1137, 1'b1, 1'b1, 4'd9);
        push(t + 1201, 1'b0, 1'b0, 4'd9);
        step(1); key_evt = 1'b0;
        step(1199);
        enable = 1'b0; key = 16'h0001; key_evt = 1'b1;
        step(1);
        enable = 1'b1; key_evt = 1'b0; key = '0;
        step(10);

        // 5b: one-cycle reset mid-note, no tail afterwards
        key = 16'h0020; key_evt = 1'b1; t = cyc;
        push(t + 1, 1'b0, 1'b1, 4'd5);
        push(t + 11, 1'b0, 1'b0, 4'd0);
        step(1); key_evt = 1'b0;
        step(9); rst_n = 1'b0;
        step(1); rst_n = 1'b1; key = '0;
        step(20);

        // 6a: key_evt with no key held does nothing
        key = '0; key_evt = 1'b1;
        step(1); key_evt = 1'b0;
        step(30);
        check("empty_evt_playing", 32'(playing), 0);
        check("empty_evt_buzzer",  32'(buzzer),  0);

        // 6b: CLK_FREQ=1000, octave 3 -> H clamps to 1, toggle every cycle
        f_key = 16'h0200; f_octave = 2'd3; f_key_evt = 1'b1; t = cyc;
        push_f(t + 1, 1'b0, 1'b1, 4'd9);
        for (int k = 1; k <= 5; k++) push_f(t + 1 + k, 1'(k % 2), 1'b1, 4'd9);
        push_f(t + 7, 1'b0, 1'b0, 4'd9);
        step(1); f_key_evt = 1'b0;
        step(5); f_key = '0;
        step(20);

        check("dut_queue_drained",  32'(exp_q.size()),   0);
        check("fast_queue_drained", 32'(exp_f_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
